ram_reader: RTL and testbench
=============================

Name: ram_reader

Overview:
Read-side counterpart to the block-RAM fill engine. On a start pulse it walks a contiguous, wrapping address range of the 64x32 dual-port RAM through the read port (addrb/dout). Each word is presented on a valid/ready output stream and accumulated into a running 32-bit sum. Its consumers are display/checker logic, which verify or show the table the fill engine wrote.

Parameters:
ADDR_W, 6, RAM address width; depth = 2^ADDR_W, addresses wrap modulo 2^ADDR_W
DATA_W, 32, RAM word width and width of data_out/sum_out
RD_LAT, 1, RAM read latency in cycles from address register to dout valid (1..3)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  first address to read; latched on accepted start
count  in  ADDR_W+1  number of words to read (0..127); latched on accepted start
addrb  out  ADDR_W  RAM read address
dout  in  DATA_W  RAM read data
data_out  out  DATA_W  registered word read from RAM
data_valid  out  1  data_out holds a word not yet accepted
data_ready  in  1  consumer accepts data_out when high with data_valid
sum_out  out  DATA_W  running sum of accepted words, modulo 2^DATA_W
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (async, rst_n=0): state=IDLE. addrb, data_out, sum_out, remaining count and wait counter are all 0. data_valid, busy and done are 0. All of this takes effect immediately, including mid-transfer. No partial word is retained.
- FSM states:
  - IDLE
    - start=1, count!=0: addrb<=base_addr, remaining<=count, sum_out<=0, go WAIT.
    - start=1, count==0: sum_out<=0, go DONE.
    - Otherwise stay.
  - WAIT: counts RD_LAT+1 cycles after each addrb update. On the edge ending the last wait cycle: data_out<=dout, data_valid<=1, go OUT.
  - OUT: data_valid=1; data_out and addrb held stable.
    - Edge with data_ready=1:
      - data_valid<=0, sum_out<=sum_out+data_out (drop carry), remaining<=remaining-1.
      - If remaining==1: go DONE.
      - Else: addrb<=addrb+1 (wraps 2^ADDR_W-1 -> 0), go WAIT.
    - data_ready=0: hold everything.
  - DONE: done=1 for exactly this cycle, then IDLE.
- busy=1 in WAIT and OUT, 0 in IDLE and DONE. busy, done and data_valid are all registered outputs.
- Latency with RD_LAT=1: start sampled at edge E0 gives first data_valid=1 after edge E0+2.
- Throughput: at most one word per RD_LAT+2 cycles. Back-pressure adds cycles one-for-one.
- start while busy or in DONE is ignored; no queuing.
- sum_out holds its final value after done until the next accepted start.
- count>2^ADDR_W is legal: the address sequence wraps and repeats.
- data_ready while data_valid=0 has no effect.

Test Plan:
1. RAM[i]=i+100; base=1, count=4, data_ready=1 -> addrb 1,2,3,4; data_out 101,102,103,104; first valid 2 cycles after the start edge; sum_out=410; single done pulse; busy low afterwards.
2. Same setup, data_ready=0 for 5 cycles while word 2 is valid -> data_out=102 and data_valid held for 5 cycles; addrb stays 2; sum_out stays 101 until acceptance; final sum_out=410.
3. base=62, count=4 -> addresses 62,63,0,1; data 162,163,100,101; sum_out=526.
4. count=0 -> no data_valid; done high in the cycle after the start edge; busy never high; sum_out=0.
5. start pulses again during transfer of case 1 -> ignored, still exactly 4 words. Then rst_n=0 mid-OUT -> busy, data_valid, done, addrb and sum_out are 0 immediately; after release the block sits in IDLE until the next start.
6. base=0, count=64 -> 64 words 100..163 in order; sum_out=8416; done once.

Source files
------------

// File: rtl/ram_reader.sv
// ram_reader: walks a wrapping RAM address range, streams each word out with valid/ready and sums the accepted words
module ram_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, WAIT, OUT, DONE} state_t;
  localparam logic [1:0] LAT = 2'(RD_LAT);
  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     rem_q;
  logic [1:0]          wait_q;
  logic [DATA_W-1:0]   data_q, sum_q;
  logic                valid_q, busy_q, done_q;
  // wait_q counts RD_LAT+1 edges after every address update before dout is captured
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sum_q <= '0;
          if (count != '0) begin
            addr_q  <= base_addr;
            rem_q   <= count;
            wait_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WAIT: if (wait_q == LAT) begin
          data_q  <= dout;
          valid_q <= 1'b1;
          state_q <= OUT;
        end else wait_q <= wait_q + 2'd1;
        OUT: if (data_ready) begin
          valid_q <= 1'b0;
          sum_q   <= sum_q + data_q;
          rem_q   <= rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            wait_q  <= '0;
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign addrb      = addr_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign sum_out    = sum_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed checks of ram_reader against a 64x32 RAM model holding i+100
module tb_ram_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, data_ready = 1'b1;
  logic [5:0]  base_addr = '0, addrb;
  logic [6:0]  count = '0;
  logic [31:0] dout = '0, data_out, sum_out;
  logic        data_valid, busy, done;
  logic [31:0] ram [64];
  int          checks = 0, errors = 0, done_cnt = 0;

  ram_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .addrb(addrb), .dout(dout), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .sum_out(sum_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) dout <= ram[addrb];
  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(input logic [5:0] b, input logic [6:0] n, input int stall_w,
                      input int stall_n, input bit ghost, input logic [31:0] exp_sum);
    logic [5:0]  a;
    logic [31:0] s;
    int          cyc, d0;
    s  = 0;
    d0 = done_cnt;
    base_addr = b;
    count     = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < int'(n); w++) begin
      a = b + 6'(w);
      data_ready = (w != stall_w);
      cyc = 0;
      while (!data_valid && cyc < 20) begin
        start = ghost && w == 1 && cyc == 0;
        tick();
        cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, 2);
      chk("addrb", addrb, 32'(a));
      chk("data_out", data_out, 32'(a) + 100);
      chk("busy", busy, 1);
      for (int k = 0; k < stall_n && w == stall_w; k++) begin
        tick();
        chk("stall_valid", data_valid, 1);
        chk("stall_data", data_out, 32'(a) + 100);
        chk("stall_addr", addrb, 32'(a));
        chk("stall_sum", sum_out, s);
      end
      data_ready = 1'b1;
      tick();
      s += 32'(a) + 100;
      chk("valid_drop", data_valid, 0);
      chk("sum_step", sum_out, s);
    end
    chk("done_hi", done, 1);
    chk("busy_end", busy, 0);
    chk("sum_final", sum_out, exp_sum);
    tick();
    chk("done_lo", done, 0);
    chk("done_once", done_cnt - d0, 1);
    tick();
    chk("no_extra", data_valid, 0);
    chk("sum_hold", sum_out, exp_sum);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'(i) + 100;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addrb, 0);
    chk("rst_sum", sum_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    xfer(6'd1, 7'd4, -1, 0, 1'b0, 32'd410);
    xfer(6'd1, 7'd4, 1, 5, 1'b0, 32'd410);
    xfer(6'd62, 7'd4, -1, 0, 1'b0, 32'd526);
    count = 7'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_valid", data_valid, 0);
    chk("z_sum", sum_out, 0);
    tick();
    chk("z_done_lo", done, 0);
    chk("z_busy2", busy, 0);
    xfer(6'd1, 7'd4, -1, 0, 1'b1, 32'd410);
    base_addr = 6'd1;
    count     = 7'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("r_sum1", sum_out, 101);
    data_ready = 1'b0;
    repeat (3) tick();
    chk("r_valid", data_valid, 1);
    chk("r_addr", addrb, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy0", busy, 0);
    chk("r_valid0", data_valid, 0);
    chk("r_done0", done, 0);
    chk("r_addr0", addrb, 0);
    chk("r_sum0", sum_out, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    data_ready = 1'b1;
    repeat (4) tick();
    chk("r_idle_busy", busy, 0);
    chk("r_idle_valid", data_valid, 0);
    chk("r_idle_done", done, 0);
    xfer(6'd0, 7'd64, -1, 0, 1'b0, 32'd8416);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
